// File: rtl/mic_sampler_ctrl.sv
// Microphone front end: periodic conversion trigger, SPI master for a serial ADC,
// power-of-two averaging of conversion words and a thermometer level meter.
module mic_sampler_ctrl #(
  parameter int SCLK_DIV   = 2,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_BITS  = 12,
  parameter int AVG_LOG2   = 0,
  parameter int LEVELS     = 8,
  parameter int LEVEL_BASE = 2048,
  parameter int LEVEL_STEP = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          period,
  input  logic                 clr_ovr,
  output logic                 spi_clk,
  output logic                 spi_cs,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic [LEVELS-1:0]    level,
  output logic                 overrun
);

  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int AW = DATA_BITS + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               state_q;
  logic [15:0]          cnt_q, per_q, per_d;
  logic                 tick_d, div_end_d, cap_d;
  logic [DW-1:0]        div_q;
  logic [BW-1:0]        bit_q;
  logic                 sclk_q, cs_q, valid_q, ovr_q;
  logic [DATA_BITS-1:0] word_q, sample_q, avg_d;
  logic [AW-1:0]        acc_q, sum_d;
  logic [CW-1:0]        avg_cnt_q;
  logic [LEVELS-1:0]    level_q, level_d;

  always_comb begin
    per_d     = (period < 16'd2) ? 16'd2 : period;
    tick_d    = (cnt_q == per_q - 16'd1);
    div_end_d = (div_q == DW'(SCLK_DIV - 1));
    // Only the data window of the frame is shifted into the word register
    cap_d     = (state_q == SHIFT) && sclk_q && (div_q == '0) &&
                (int'(bit_q) >= LEAD_BITS) && (int'(bit_q) < LEAD_BITS + DATA_BITS);
    sum_d     = acc_q + AW'(word_q);
    avg_d     = DATA_BITS'(sum_d >> AVG_LOG2);
    level_d   = '0;
    for (int i = 0; i < LEVELS; i++)
      level_d[i] = ($unsigned(32'(avg_d)) >= $unsigned(32'(LEVEL_BASE + i * LEVEL_STEP)));
  end

  // The period is re-sampled only on wrap so a running interval is never cut short
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      per_q <= per_d;
    end else if (tick_d) begin
      cnt_q <= '0;
      per_q <= per_d;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      word_q    <= '0;
      sample_q  <= '0;
      level_q   <= '0;
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (tick_d && state_q != IDLE) ovr_q <= 1'b1;
      else if (clr_ovr)              ovr_q <= 1'b0;
      if (cap_d) word_q <= DATA_BITS'({word_q, spi_miso});
      case (state_q)
        IDLE: if (tick_d) begin
          state_q <= SETUP;
          cs_q    <= 1'b0;
          div_q   <= '0;
        end
        SETUP: if (div_end_d) begin
          state_q <= SHIFT;
          div_q   <= '0;
          sclk_q  <= 1'b0;
          bit_q   <= '0;
        end else div_q <= div_q + DW'(1);
        SHIFT: if (div_end_d) begin
          div_q <= '0;
          if (!sclk_q) sclk_q <= 1'b1;
          else if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_q <= HOLD;
            cs_q    <= 1'b1;
          end else begin
            bit_q  <= bit_q + BW'(1);
            sclk_q <= 1'b0;
          end
        end else div_q <= div_q + DW'(1);
        HOLD: if (div_end_d) begin
          state_q <= IDLE;
          div_q   <= '0;
          if (avg_cnt_q == CW'((1 << AVG_LOG2) - 1)) begin
            sample_q  <= avg_d;
            level_q   <= level_d;
            valid_q   <= 1'b1;
            acc_q     <= '0;
            avg_cnt_q <= '0;
          end else begin
            acc_q     <= sum_d;
            avg_cnt_q <= avg_cnt_q + CW'(1);
          end
        end else div_q <= div_q + DW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_clk      = sclk_q;
  assign spi_cs       = cs_q;
  assign spi_mosi     = 1'b0;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign level        = level_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_mic_sampler_ctrl.sv
// Bench for mic_sampler_ctrl: cycle-indexed event model of the conversion timeline
// checked every cycle, plus directed literal checks; a second instance averages 4 words.
module tb_mic_sampler_ctrl;
  localparam int D = 2, F = 16;
  localparam int L = 1 + D * (2 * F + 2);

  logic        clk = 1'b0, rst = 1'b0, clr_ovr = 1'b0, miso_a = 1'b0, miso_b = 1'b0;
  logic [15:0] period = 16'd40;
  logic        a_clk, a_cs, a_mosi, a_valid, a_ovr;
  logic        b_clk, b_cs, b_mosi, b_valid, b_ovr;
  logic [11:0] a_sample, b_sample;
  logic [7:0]  a_level, b_level;

  always #5 clk = ~clk;

  mic_sampler_ctrl u_dut (
    .clk(clk), .rst(rst), .period(period), .clr_ovr(clr_ovr),
    .spi_clk(a_clk), .spi_cs(a_cs), .spi_mosi(a_mosi), .spi_miso(miso_a),
    .sample(a_sample), .sample_valid(a_valid), .level(a_level), .overrun(a_ovr));

  mic_sampler_ctrl #(.AVG_LOG2(2)) u_avg (
    .clk(clk), .rst(rst), .period(period), .clr_ovr(clr_ovr),
    .spi_clk(b_clk), .spi_cs(b_cs), .spi_mosi(b_mosi), .spi_miso(miso_b),
    .sample(b_sample), .sample_valid(b_valid), .level(b_level), .overrun(b_ovr));

  int errors = 0, checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int thermo(input int s);
    int r = 0;
    for (int i = 0; i < 8; i++) if (s >= 2048 + 256 * i) r |= (1 << i);
    return r;
  endfunction

  // Model: conversion k accepted at cycle t0 owns cycles t0+1..t0+L-1, strobe at t0+L
  logic [15:0] frames [64];
  logic [15:0] m_frame = 16'h0;
  int  mcnt = 0, mP = 2, t0 = -1000, m_k = 0, m_word = 0, m_sample = 0;
  bit  m_ovr = 0, m_valid = 0;

  always @(posedge clk) begin : model
    bit tick, busy;
    if (!rst) begin
      mcnt = 0; mP = (period < 2) ? 2 : int'(period);
      t0 = -1000; m_ovr = 0; m_valid = 0; m_sample = 0; m_k = 0;
    end else begin
      tick = (mcnt == mP - 1);
      busy = (cyc - t0 >= 1) && (cyc - t0 <= L - 1);
      if (tick) begin mcnt = 0; mP = (period < 2) ? 2 : int'(period); end
      else mcnt++;
      if (tick && busy) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
      if (tick && !busy) begin
        t0 = cyc; m_frame = frames[m_k % 64]; m_word = int'(m_frame & 16'h0FFF); m_k++;
      end
      m_valid = (cyc + 1 == t0 + L);
      if (m_valid) m_sample = m_word;
    end
    cyc++;
  end

  // ADC stand-in: presents the next frame bit on each falling spi_clk while selected
  logic [15:0] cur_a = 16'h0, cur_b = 16'h0;
  int bp_a = -1, bp_b = -1;
  always @(negedge a_cs) begin cur_a = m_frame; bp_a = 15; end
  always @(negedge a_clk) if (!a_cs && bp_a >= 0) begin miso_a = cur_a[bp_a]; bp_a--; end
  always @(negedge b_cs) begin cur_b = m_frame; bp_b = 15; end
  always @(negedge b_clk) if (!b_cs && bp_b >= 0) begin miso_b = cur_b[bp_b]; bp_b--; end

  int last_fall = -1, last_valid = -1, vcnt_a = 0, vcnt_b = 0, rises = 0;
  logic prev_cs = 1'b1, prev_clk = 1'b1;

  always @(negedge clk) begin : compare
    int o, s, e_cs, e_clk;
    o = cyc - t0;
    s = cyc - (t0 + 1 + D);
    e_cs  = (o >= 1 && o <= D + 2 * D * F) ? 0 : 1;
    e_clk = (s >= 0 && s < 2 * D * F) ? (((s % (2 * D)) >= D) ? 1 : 0) : 1;
    chk("spi_cs", a_cs, e_cs);
    chk("spi_clk", a_clk, e_clk);
    chk("spi_mosi", a_mosi, 0);
    chk("sample_valid", a_valid, m_valid);
    chk("sample", a_sample, m_sample);
    chk("level", a_level, thermo(m_sample));
    chk("overrun", a_ovr, m_ovr);
    chk("avg_spi_cs", b_cs, e_cs);
    chk("avg_spi_clk", b_clk, e_clk);
    chk("avg_overrun", b_ovr, m_ovr);
    if (prev_cs && !a_cs) last_fall = cyc;
    if (!prev_clk && a_clk && !a_cs) rises++;
    if (a_valid) begin vcnt_a++; last_valid = cyc; end
    if (b_valid) vcnt_b++;
    prev_cs = a_cs; prev_clk = a_clk;
  end

  int rel, base_a, base_b, base_r;

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] p);
    @(negedge clk);
    period = p; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rel = cyc; base_a = vcnt_a; base_b = vcnt_b; base_r = rises;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 64; i++) frames[i] = 16'((i * 16'h2F3B) ^ 16'hA5C3);
  endtask

  initial begin
    fill_default();
    // Reset mid-frame after a collision has set overrun
    do_reset(16'd40);
    wait_until(rel + 140);
    chk("t1_pre_overrun", a_ovr, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rst_cs", a_cs, 1);
    chk("t1_rst_clk", a_clk, 1);
    chk("t1_rst_sample", a_sample, 0);
    chk("t1_rst_level", a_level, 0);
    chk("t1_rst_overrun", a_ovr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single conversion with defaults
    frames[0] = 16'h0ABC;
    do_reset(16'd200);
    wait_until(rel + 270);
    chk("t2_cs_fall", last_fall, rel + 200);
    chk("t2_valid_cycle", last_valid, rel + 268);
    chk("t2_valid_count", vcnt_a - base_a, 1);
    chk("t2_sclk_rises", rises - base_r, 16);
    chk("t2_sample", a_sample, 12'hABC);
    chk("t2_level", a_level, 8'h07);

    // Overrun with period shorter than a frame
    fill_default();
    do_reset(16'd40);
    wait_until(rel + 100);
    chk("t3_overrun_set", a_ovr, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    wait_until(rel + 120);
    chk("t3_overrun_cleared", a_ovr, 0);
    wait_until(rel + 170);
    chk("t3_overrun_reset", a_ovr, 1);
    wait_until(rel + 239);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    wait_until(rel + 241);
    chk("t3_overrun_wins_clr", a_ovr, 1);
    wait_until(rel + 400);
    chk("t3_valid_count", vcnt_a - base_a, 4);

    // Averaging over four words on the second instance
    frames[0] = 16'h0100; frames[1] = 16'h0101; frames[2] = 16'h0102; frames[3] = 16'h0104;
    do_reset(16'd200);
    wait_until(rel + 700);
    chk("t4_avg_no_early_valid", vcnt_b - base_b, 0);
    wait_until(rel + 900);
    chk("t4_avg_valid_count", vcnt_b - base_b, 1);
    chk("t4_avg_sample", b_sample, 12'h101);
    chk("t4_avg_level", b_level, 0);
    chk("t4_plain_sample", a_sample, 12'h104);

    // Degenerate periods and a mid-count period change
    fill_default();
    do_reset(16'd0);
    wait_until(rel + 10);
    chk("t5_p0_overrun", a_ovr, 1);
    wait_until(rel + 71);
    chk("t5_p0_first_fall", last_fall, rel + 2);
    wait_until(rel + 75);
    chk("t5_p0_second_fall", last_fall, rel + 72);
    do_reset(16'd1);
    wait_until(rel + 5);
    chk("t5_p1_first_fall", last_fall, rel + 2);
    do_reset(16'd200);
    wait_until(rel + 100);
    period = 16'd400;
    wait_until(rel + 300);
    chk("t5_interval_200", last_fall, rel + 200);
    wait_until(rel + 650);
    chk("t5_interval_400", last_fall, rel + 600);

    // Level thresholds; lead bits of the first frame must be discarded
    frames[0] = 16'hF7FF; frames[1] = 16'h0800; frames[2] = 16'h0FFF;
    frames[3] = 16'h3F00; frames[4] = 16'h0EFF;
    do_reset(16'd100);
    wait_until(rel + 170);
    chk("t6_7ff_sample", a_sample, 12'h7FF);
    chk("t6_7ff_level", a_level, 8'h00);
    wait_until(rel + 270);
    chk("t6_800_sample", a_sample, 12'h800);
    chk("t6_800_level", a_level, 8'h01);
    wait_until(rel + 370);
    chk("t6_fff_level", a_level, 8'hFF);
    wait_until(rel + 470);
    chk("t6_f00_level", a_level, 8'hFF);
    wait_until(rel + 570);
    chk("t6_eff_level", a_level, 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
